clock_set_controller: RTL and testbench



---
 rtl/clock_set_controller.sv | 105 ++++++++++
 tb/tb_clock_set_controller.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_controller.sv
// clock_set_controller: front-panel time display selection and HH/MM/SS setting FSM
//
// Ports:
//   clk                - clock
//   reset              - synchronous, active-high reset
//   btn_mode           - single-cycle pulse: advance field / enter / confirm
//   btn_inc            - single-cycle pulse: increment the selected field
//   time_bcd[23:0]     - live time from the counter (HH:MM:SS, BCD)
//   display_data[23:0] - BCD to the display driver (live time or edit buffer)
//   digit_enable_mask  - per-digit enable, selected field blinks while editing
//   time_load          - one-cycle pulse loading time_load_value into the counter
//   time_load_value    - edited time, held until the next load
//   setting            - high in any SET state
//
// Optional feature: define CLOCK_SET_LEADING_ZERO_BLANK_EN to blank the hours-tens
// digit whenever it is zero (applies in all states, overrides blink).
module clock_set_controller #(
    parameter int CLK_RATE_HZ    = 390625,
    parameter int BLINK_RATE_HZ  = 2,
    parameter int IDLE_TIMEOUT_S = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic [23:0] time_bcd,
    output logic [23:0] display_data,
    output logic [5:0]  digit_enable_mask,
    output logic        time_load,
    output logic [23:0] time_load_value,
    output logic        setting
);
    localparam int IDLE_CYCLES = IDLE_TIMEOUT_S * CLK_RATE_HZ;
    localparam int HALF        = CLK_RATE_HZ / (2 * BLINK_RATE_HZ);
    localparam int IW          = IDLE_CYCLES > 1 ? $clog2(IDLE_CYCLES) : 1;
    localparam int BW          = HALF > 1 ? $clog2(HALF) : 1;

    typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} state_t;

    state_t        state_q, state_d;
    logic [23:0]   edit_q, edit_d, inc_edit, disp_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d, load_d, btn, idle_hit, half_hit, in_run;
    logic [5:0]    sel, mask_d;

    // Out-of-range or non-BCD values restart at 00; v >= lim is safe once both nibbles are BCD.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        return (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v >= lim) ? 8'h00 :
               (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'h0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        btn      = btn_mode | btn_inc;
        in_run   = state_q == RUN;
        idle_hit = idle_q == IW'(IDLE_CYCLES - 1);
        half_hit = blink_q == BW'(HALF - 1);
        inc_edit = state_q == SET_H ? {bcd_inc(edit_q[23:16], 8'h23), edit_q[15:0]} :
                   state_q == SET_M ? {edit_q[23:16], bcd_inc(edit_q[15:8], 8'h59), edit_q[7:0]} :
                                      {edit_q[23:8], bcd_inc(edit_q[7:0], 8'h59)};
        // btn_mode has priority; btn_inc only counts when btn_mode is absent.
        state_d  = in_run ? (btn_mode ? SET_H : RUN) :
                   btn_mode ? (state_q == SET_H ? SET_M : state_q == SET_M ? SET_S : RUN) :
                   (!btn_inc && idle_hit) ? RUN : state_q;
        edit_d   = (in_run && btn_mode) ? time_bcd :
                   (!in_run && !btn_mode && btn_inc) ? inc_edit : edit_q;
        load_d   = state_q == SET_S && btn_mode;
        idle_d   = (in_run || btn) ? '0 : idle_q + 1'b1;
        blink_d  = (in_run || btn || half_hit) ? '0 : blink_q + 1'b1;
        phase_d  = (in_run || btn) ? 1'b1 : half_hit ? ~phase_q : phase_q;
        sel      = state_d == SET_H ? 6'b110000 : state_d == SET_M ? 6'b001100 :
                   state_d == SET_S ? 6'b000011 : 6'b000000;
        disp_d   = state_d == RUN ? time_bcd : edit_d;
        mask_d   = phase_d ? 6'b111111 : ~sel;
`ifdef CLOCK_SET_LEADING_ZERO_BLANK_EN
        mask_d[5] = mask_d[5] & (disp_d[23:20] != 4'd0);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= RUN;
            edit_q            <= '0;
            idle_q            <= '0;
            blink_q           <= '0;
            phase_q           <= 1'b1;
            display_data      <= '0;
            digit_enable_mask <= '0;
            time_load         <= 1'b0;
            time_load_value   <= '0;
            setting           <= 1'b0;
        end else begin
            state_q           <= state_d;
            edit_q            <= edit_d;
            idle_q            <= idle_d;
            blink_q           <= blink_d;
            phase_q           <= phase_d;
            display_data      <= disp_d;
            digit_enable_mask <= mask_d;
            time_load         <= load_d;
            time_load_value   <= load_d ? edit_q : time_load_value;
            setting           <= state_d != RUN;
        end
    end
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: directed and randomized checks against a behavioural model
module tb_clock_set_controller;
    localparam int CLK_HZ = 1000, BLINK_HZ = 25, IDLE_S = 1;
    localparam int IDLE = CLK_HZ * IDLE_S, HALF = CLK_HZ / (2 * BLINK_HZ);

    logic        clk = 1'b0, reset = 1'b1, btn_mode = 1'b0, btn_inc = 1'b0;
    logic [23:0] time_bcd = '0;
    logic [23:0] display_data, time_load_value;
    logic [5:0]  digit_enable_mask;
    logic        time_load, setting;

    clock_set_controller #(.CLK_RATE_HZ(CLK_HZ), .BLINK_RATE_HZ(BLINK_HZ), .IDLE_TIMEOUT_S(IDLE_S)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc), .time_bcd(time_bcd),
        .display_data(display_data), .digit_enable_mask(digit_enable_mask), .time_load(time_load),
        .time_load_value(time_load_value), .setting(setting)
    );

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;
    // Model: mode 0 = live time, 1/2/3 = editing hours/minutes/seconds.
    int          mode = 0, since = 0;
    logic [23:0] m_edit = '0, m_lv = '0;
    logic        m_load = 1'b0;
    logic [23:0] cur_t = '0;

    function automatic logic [7:0] to_bcd(input int n);
        return 8'((n / 10) * 16 + n % 10);
    endfunction

    function automatic logic [7:0] field_inc(input logic [7:0] v, input int lim);
        int t, u, n;
        t = int'(v[7:4]);
        u = int'(v[3:0]);
        if (t > 9 || u > 9) return 8'h00;
        n = t * 10 + u;
        if (n > lim) return 8'h00;
        return to_bcd((n + 1) % (lim + 1));
    endfunction

    function automatic logic [23:0] exp_disp();
        return mode == 0 ? cur_t : m_edit;
    endfunction

    function automatic logic [5:0] exp_mask();
        logic [5:0] m;
        logic       on;
        on = ((since / HALF) % 2) == 0;
        m = 6'b111111;
        if (mode != 0 && !on) m = mode == 1 ? 6'b001111 : mode == 2 ? 6'b110011 : 6'b111100;
`ifdef CLOCK_SET_LEADING_ZERO_BLANK_EN
        if (exp_disp() >> 20 == 24'd0) m[5] = 1'b0;
`endif
        return m;
    endfunction

    task automatic check(input string tag, input logic [23:0] act, input logic [23:0] exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_edge(input logic bm, input logic bi, input logic [23:0] t);
        cur_t  = t;
        m_load = 1'b0;
        if (mode == 0) begin
            if (bm) begin
                mode   = 1;
                m_edit = t;
                since  = 0;
            end
        end else if (bm) begin
            if (mode == 3) begin
                m_load = 1'b1;
                m_lv   = m_edit;
                mode   = 0;
            end else mode++;
            since = 0;
        end else if (bi) begin
            if (mode == 1) m_edit[23:16] = field_inc(m_edit[23:16], 23);
            else if (mode == 2) m_edit[15:8] = field_inc(m_edit[15:8], 59);
            else m_edit[7:0] = field_inc(m_edit[7:0], 59);
            since = 0;
        end else begin
            since++;
            if (since == IDLE) mode = 0;
        end
    endtask

    task automatic step(input logic bm, input logic bi, input logic [23:0] t);
        @(negedge clk);
        btn_mode = bm;
        btn_inc  = bi;
        time_bcd = t;
        @(posedge clk);
        model_edge(bm, bi, t);
        #1;
        check("display", display_data, exp_disp());
        check("mask", 24'(digit_enable_mask), 24'(exp_mask()));
        check("setting", 24'(setting), 24'(mode != 0));
        check("load", 24'(time_load), 24'(m_load));
        check("load_value", time_load_value, m_lv);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset    = 1'b1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_display", display_data, 24'h0);
        check("rst_mask", 24'(digit_enable_mask), 24'h0);
        check("rst_load", 24'(time_load), 24'h0);
        check("rst_load_value", time_load_value, 24'h0);
        check("rst_setting", 24'(setting), 24'h0);
        mode  = 0;
        since = 0;
        m_lv  = '0;
        m_edit = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [23:0] t;
        logic        bm, bi;
        do_reset(3);
        repeat (3) step(1'b0, 1'b0, 24'h123456);
        check("run_display", display_data, 24'h123456);
        check("run_mask", 24'(digit_enable_mask), 24'h3f);
        step(1'b0, 1'b1, 24'h123456);
        check("run_inc_ignored", 24'(setting), 24'h0);

        step(1'b1, 1'b0, 24'h225930);
        step(1'b0, 1'b1, 24'h225930);
        check("hour_23", display_data, 24'h235930);
        step(1'b0, 1'b1, 24'h225930);
        check("hour_wrap", display_data, 24'h005930);
        step(1'b1, 1'b0, 24'h225930);
        step(1'b1, 1'b0, 24'h225930);
        step(1'b1, 1'b0, 24'h225930);
        check("confirm_load", 24'(time_load), 24'h1);
        check("confirm_value", time_load_value, 24'h005930);
        step(1'b0, 1'b0, 24'h225930);
        check("load_one_cycle", 24'(time_load), 24'h0);

        step(1'b1, 1'b0, 24'h105907);
        step(1'b1, 1'b0, 24'h105907);
        step(1'b0, 1'b1, 24'h105907);
        check("min_wrap", display_data, 24'h100007);
        step(1'b1, 1'b1, 24'h105907);
        check("mode_wins", display_data, 24'h100007);
        repeat (IDLE - 1) step(1'b0, 1'b0, 24'h105907);
        check("idle_before", 24'(setting), 24'h1);
        step(1'b0, 1'b0, 24'h105907);
        check("idle_abort", 24'(setting), 24'h0);
        check("idle_no_load", 24'(time_load), 24'h0);

        step(1'b1, 1'b0, 24'h105907);
        repeat (HALF - 1) step(1'b0, 1'b0, 24'h105907);
        check("blink_on", 24'(digit_enable_mask), 24'h3f);
        step(1'b0, 1'b0, 24'h105907);
        check("blink_off", 24'(digit_enable_mask), 24'h0f);
        repeat (5) step(1'b0, 1'b0, 24'h105907);
        step(1'b0, 1'b1, 24'h105907);
        check("blink_force_on", 24'(digit_enable_mask[5:4]), 24'h3);
        do_reset(2);
        step(1'b0, 1'b0, 24'h105907);
        check("reset_mid_edit", 24'(setting), 24'h0);

        step(1'b0, 1'b0, 24'h090000);
`ifdef CLOCK_SET_LEADING_ZERO_BLANK_EN
        check("lz_blank", 24'(digit_enable_mask), 24'h1f);
`else
        check("lz_no_blank", 24'(digit_enable_mask), 24'h3f);
`endif
        step(1'b0, 1'b0, 24'h100000);
        check("lz_ten", 24'(digit_enable_mask), 24'h3f);

        t = 24'h000000;
        for (int i = 0; i < 5000; i++) begin
            if (i % 7 == 0)
                t = $urandom_range(0, 3) == 0 ? 24'($urandom) :
                    {to_bcd($urandom_range(0, 23)), to_bcd($urandom_range(0, 59)), to_bcd($urandom_range(0, 59))};
            if (i < 2500) begin
                bm = $urandom_range(0, 5) == 0;
                bi = $urandom_range(0, 2) == 0;
            end else begin
                bm = $urandom_range(0, 1499) == 0;
                bi = $urandom_range(0, 1499) == 0;
            end
            step(bm, bi, t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
